// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Time-setting controller for the clock board. Takes debounced, active-low,
//   one-tick key strobes. On MODE it copies the running time into shadow
//   registers and walks the user through hour -> minute -> second editing.
//   A final MODE commits the shadows with a one-cycle load strobe. CANCEL, or
//   TIMEOUT_MS ticks with no key, abandons the edit without a load. The block
//   also produces a blink enable for the field being edited.
//
// Ports
//   Millisecond_in  1 kHz tick clock, rising edge active
//   Reset           asynchronous, active-high reset
//   KEY_pulse[0:3]  active-low key strobes: [0]=MODE [1]=UP [2]=DOWN [3]=CANCEL
//   Hour_in         running hour   0..23
//   Minute_in       running minute 0..59
//   Second_in       running second 0..59
//   Hour_out        shadow hour
//   Minute_out      shadow minute
//   Second_out      shadow second
//   Load_en         one-cycle commit strobe for the time counter
//   Set_field       0=RUN 1=hour 2=minute 3=second
//   Blink           display enable for the edited field (1 in RUN)
module time_set_ctrl #(
  parameter int TIMEOUT_MS = 30000,
  parameter int BLINK_HALF = 250
) (
  input  logic       Millisecond_in,
  input  logic       Reset,
  input  logic [0:3] KEY_pulse,
  input  logic [4:0] Hour_in,
  input  logic [5:0] Minute_in,
  input  logic [5:0] Second_in,
  output logic [4:0] Hour_out,
  output logic [5:0] Minute_out,
  output logic [5:0] Second_out,
  output logic       Load_en,
  output logic [1:0] Set_field,
  output logic       Blink
);

  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT_MS - 1);
  localparam logic [9:0]  BLINK_LAST = 10'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        commit;
  logic [15:0] idle_cnt;
  logic [9:0]  blink_cnt;

  // Modular increment/decrement; out-of-range values fold back into range
  function automatic logic [4:0] hour_step(input logic [4:0] v, input logic up);
    if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic up);
    if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
  endfunction

  // Captured values are forced legal so the shadows never leave their range
  function automatic logic [4:0] hour_legal(input logic [4:0] v);
    return (v > 5'd23) ? 5'd0 : v;
  endfunction

  function automatic logic [5:0] sixty_legal(input logic [5:0] v);
    return (v > 6'd59) ? 6'd0 : v;
  endfunction

  // Key decode with priority CANCEL > MODE > UP > DOWN
  logic any_key, cancel_key, mode_key, up_key, down_key;
  logic in_set, timeout_hit, capture;

  assign any_key    = ~&KEY_pulse;
  assign cancel_key = ~KEY_pulse[3];
  assign mode_key   =  KEY_pulse[3] & ~KEY_pulse[0];
  assign up_key     =  KEY_pulse[3] &  KEY_pulse[0] & ~KEY_pulse[1];
  assign down_key   =  KEY_pulse[3] &  KEY_pulse[0] &  KEY_pulse[1] & ~KEY_pulse[2];

  assign in_set      = (state != RUN);
  // A key in the same tick as the timeout wins, so timeout requires no key
  assign timeout_hit = in_set && !any_key && (idle_cnt == IDLE_LAST);
  assign capture     = (state == RUN) && mode_key;

  // State register
  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    unique case (state)
      RUN: begin
        if (mode_key) state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (cancel_key || timeout_hit) state_next = RUN;
        else if (mode_key)             state_next = SET_MIN;
      end
      SET_MIN: begin
        if (cancel_key || timeout_hit) state_next = RUN;
        else if (mode_key)             state_next = SET_SEC;
      end
      SET_SEC: begin
        if (cancel_key || timeout_hit) state_next = RUN;
        else if (mode_key) begin
          state_next = RUN;
          commit     = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Output decode
  always_comb begin
    Set_field = state;
  end

  // Commit strobe is registered so the load lands with the final shadows
  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) Load_en <= 1'b0;
    else       Load_en <= commit;
  end

  // Shadow registers
  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) begin
      Hour_out   <= 5'd0;
      Minute_out <= 6'd0;
      Second_out <= 6'd0;
    end else if (capture) begin
      Hour_out   <= hour_legal(Hour_in);
      Minute_out <= sixty_legal(Minute_in);
      Second_out <= sixty_legal(Second_in);
    end else if (up_key || down_key) begin
      unique case (state)
        SET_HOUR: Hour_out   <= hour_step(Hour_out, up_key);
        SET_MIN:  Minute_out <= sixty_step(Minute_out, up_key);
        SET_SEC:  Second_out <= sixty_step(Second_out, up_key);
        default:  ;
      endcase
    end
  end

  // Idle counter: zero in RUN, on any key and on entry to a SET state
  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) begin
      idle_cnt <= 16'd0;
    end else if (state_next == RUN || state == RUN || any_key) begin
      idle_cnt <= 16'd0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Blink generator: restarts high on any key or SET entry, toggles on wrap
  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) begin
      blink_cnt <= 10'd0;
      Blink     <= 1'b1;
    end else if (state_next == RUN || state == RUN || any_key) begin
      blink_cnt <= 10'd0;
      Blink     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= 10'd0;
      Blink     <= ~Blink;
    end else begin
      blink_cnt <= blink_cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl. Stimulus pushes the reference model's expected
// outputs for each tick into a queue; a monitor pops and compares one entry
// per tick, sampled between clock edges.
module tb_time_set_ctrl;

  localparam int TMO = 40;
  localparam int BH  = 6;

  localparam logic [0:3] K_NONE   = 4'b1111;
  localparam logic [0:3] K_MODE   = 4'b0111;
  localparam logic [0:3] K_UP     = 4'b1011;
  localparam logic [0:3] K_DOWN   = 4'b1101;
  localparam logic [0:3] K_CANCEL = 4'b1110;

  logic       clk = 1'b0;
  logic       Reset;
  logic [0:3] keys;
  logic [4:0] hin;
  logic [5:0] min_in;
  logic [5:0] sin;
  logic [4:0] Hour_out;
  logic [5:0] Minute_out;
  logic [5:0] Second_out;
  logic       Load_en;
  logic [1:0] Set_field;
  logic       Blink;

  time_set_ctrl #(.TIMEOUT_MS(TMO), .BLINK_HALF(BH)) dut (
    .Millisecond_in(clk),
    .Reset(Reset),
    .KEY_pulse(keys),
    .Hour_in(hin),
    .Minute_in(min_in),
    .Second_in(sin),
    .Hour_out(Hour_out),
    .Minute_out(Minute_out),
    .Second_out(Second_out),
    .Load_en(Load_en),
    .Set_field(Set_field),
    .Blink(Blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sf;
    int h;
    int m;
    int s;
    bit ld;
    bit bl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_loads = 0;
  int   obs_loads = 0;

  // Reference model: editing mode, three fields, ticks since last activity
  int md;
  int fld[1:3];
  int since;

  function automatic int modulus(input int f);
    return (f == 1) ? 24 : 60;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    md = 0; since = 0;
    for (int f = 1; f <= 3; f++) fld[f] = 0;
  endtask

  task automatic model_edge(input logic [0:3] k, input int h, input int m, input int s);
    exp_t e;
    bit pk, cn, mo, upk, dn, ld;
    pk  = (k != K_NONE);
    cn  = !k[3];
    mo  = k[3] && !k[0];
    upk = k[3] && k[0] && !k[1];
    dn  = k[3] && k[0] && k[1] && !k[2];
    ld  = 0;
    if (md == 0) begin
      if (mo) begin
        fld[1] = h; fld[2] = m; fld[3] = s;
        md = 1; since = 0;
      end
    end else begin
      if (cn) md = 0;
      else if (mo) begin
        if (md == 3) begin md = 0; ld = 1; end
        else md = md + 1;
      end
      else if (upk) fld[md] = (fld[md] + 1) % modulus(md);
      else if (dn)  fld[md] = (fld[md] + modulus(md) - 1) % modulus(md);
      else begin
        since = since + 1;
        if (since == TMO) md = 0;
      end
      if (pk) since = 0;
    end
    if (md == 0) since = 0;
    e.sf = md; e.h = fld[1]; e.m = fld[2]; e.s = fld[3]; e.ld = ld;
    e.bl = (md == 0) ? 1'b1 : (((since / BH) % 2) == 0);
    if (ld) exp_loads++;
    exp_q.push_back(e);
  endtask

  task automatic step_in(input logic [0:3] k, input int h, input int m, input int s);
    @(negedge clk);
    keys = k; hin = 5'(h); min_in = 6'(m); sin = 6'(s);
    model_edge(k, h, m, s);
  endtask

  task automatic step(input logic [0:3] k);
    step_in(k, $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
  endtask

  task automatic idle(input int n);
    repeat (n) step(K_NONE);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_set_field"}, 16'(Set_field), 16'd0);
    chk({tag, "_hour"},      16'(Hour_out),  16'd0);
    chk({tag, "_minute"},    16'(Minute_out), 16'd0);
    chk({tag, "_second"},    16'(Second_out), 16'd0);
    chk({tag, "_load"},      16'(Load_en),   16'd0);
    chk({tag, "_blink"},     16'(Blink),     16'd1);
  endtask

  // Release at a falling edge and model the very next rising edge
  task automatic release_reset();
    @(negedge clk);
    Reset = 1'b0;
    model_reset();
    keys = K_NONE; hin = 5'd7; min_in = 6'd8; sin = 6'd9;
    model_edge(K_NONE, 7, 8, 9);
  endtask

  task automatic async_reset();
    @(negedge clk);
    keys = K_NONE;
    #2 Reset = 1'b1;
    #1 check_reset("async_rst");
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("set_field", 16'(Set_field),  16'(e.sf));
        chk("hour",      16'(Hour_out),   16'(e.h));
        chk("minute",    16'(Minute_out), 16'(e.m));
        chk("second",    16'(Second_out), 16'(e.s));
        chk("load_en",   16'(Load_en),    16'(e.ld));
        chk("blink",     16'(Blink),      16'(e.bl));
        if (Load_en === 1'b1) obs_loads++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [0:3] rk;
    int pct;
    Reset = 1'b0; keys = K_NONE; hin = '0; min_in = '0; sin = '0;
    model_reset();
    #1 Reset = 1'b1;
    #1 check_reset("por");
    release_reset();
    idle(3);

    // Enter edit at 13:45:30, hour wraps through 23 -> 0
    step_in(K_MODE, 13, 45, 30);
    repeat (11) step(K_UP);
    step(K_MODE);
    repeat (15) step(K_UP);
    step(K_DOWN);
    step(K_MODE);
    step(K_MODE);
    idle(3);

    // Simultaneous keys resolved by priority
    step(K_MODE);
    step(4'b0011);
    step(4'b0110);
    idle(2);
    step(K_CANCEL);
    step(K_UP);
    idle(1);

    // Timeout with blink running
    step(K_MODE);
    idle(TMO + 5);

    // Asynchronous reset mid minute edit
    step(K_MODE);
    step(K_MODE);
    repeat (3) step(K_UP);
    async_reset();
    idle(4);

    // Blink restart in SET_SEC
    repeat (3) step(K_MODE);
    idle(BH + 2);
    step(K_UP);
    idle(BH + 1);
    step(K_CANCEL);
    idle(2);

    // Randomized sessions at varying key density
    for (int seg = 0; seg < 8; seg++) begin
      pct = (seg % 2 == 0) ? 35 : 2;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < pct) begin
          rk = 4'($urandom_range(0, 14));
          if ($urandom_range(0, 3) == 0) rk = K_MODE;
          step(rk);
        end else begin
          step(K_NONE);
        end
      end
    end
    idle(2);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    chk("drain", 16'(exp_q.size()), 16'd0);
    chk("load_count", 16'(obs_loads), 16'(exp_loads));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the clock board. Consumes the debounced, active-low, one-tick key pulses produced by the key debouncer. It sequences the user through hour/minute/second editing using shadow registers, and commits the edited time to the timekeeping counters with a single-cycle load strobe. It sits between the key debouncer and the time counter / display blocks, and also drives the field-blink enable for the display.

## Interface
Parameters:
- TIMEOUT_MS, 30000: ticks without any key pulse before an edit session is abandoned (1..65535).
- BLINK_HALF, 250: ticks per half-period of the blink signal (1..1023).

Ports:
- Millisecond_in  input  1  1 kHz tick clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- KEY_pulse  input  [0:3]  debounced key strobes, active-low, one cycle wide. [0]=MODE, [1]=UP, [2]=DOWN, [3]=CANCEL.
- Hour_in  input  5  current hour from the time counter, 0..23.
- Minute_in  input  6  current minute, 0..59.
- Second_in  input  6  current second, 0..59.
- Hour_out  output  5  shadow hour.
- Minute_out  output  6  shadow minute.
- Second_out  output  6  shadow second.
- Load_en  output  1  one-cycle commit strobe; the time counter loads the *_out values.
- Set_field  output  2  0=RUN, 1=hour, 2=minute, 3=second being edited.
- Blink  output  1  display enable for the edited field; constant 1 in RUN.

## Operation
- A key is "pressed" in a cycle when its KEY_pulse bit is 0. Only one key is acted on per cycle, by priority CANCEL > MODE > UP > DOWN. Lower-priority keys in the same cycle are ignored.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC. Set_field encodes the state as 0..3.
- RUN + MODE: capture Hour_in/Minute_in/Second_in into the shadows and go to SET_HOUR. UP/DOWN/CANCEL are ignored in RUN.
- MODE advances SET_HOUR -> SET_MIN -> SET_SEC.
- SET_SEC + MODE: go to RUN and assert Load_en for exactly one cycle.
- CANCEL in any SET state: go to RUN with no Load_en. Shadows keep their edited values.
- UP/DOWN modify only the field of the current state:
  - Hour wraps 23->0 on UP and 0->23 on DOWN.
  - Minute and second wrap 59->0 on UP and 0->59 on DOWN.
  - Shadow values outside the legal range are never produced.
- Timeout:
  - A 16-bit idle counter clears on any key press and on entry to a SET state, and increments every cycle while in a SET state.
  - When it reaches TIMEOUT_MS-1 the FSM goes to RUN with no Load_en. Behaviour is the same as CANCEL.
  - The counter holds at 0 in RUN.
- Blink:
  - A 10-bit counter runs 0..BLINK_HALF-1 while in a SET state and toggles Blink on wrap.
  - Any key press, and entry into a SET state, forces Blink=1 and clears the counter.
  - In RUN, Blink=1 and the counter is 0.

## Timing
- All state updates occur on the rising edge of Millisecond_in. A key pulse sampled at edge N takes effect in outputs after edge N; latency is 1 cycle.
- Load_en is registered. It is high for the cycle following the commit edge, and the *_out values are stable and final during that cycle.
- Shadows captured on RUN->SET_HOUR reflect the *_in values sampled at that same edge.
- Reset (asynchronous, any time, including mid-edit) forces:
  - state RUN, Set_field=0;
  - Hour_out=0, Minute_out=0, Second_out=0;
  - Load_en=0, Blink=1;
  - idle and blink counters cleared.
- No Load_en may be emitted during or directly out of reset.
- A timeout and a key press in the same cycle: the key press wins. The idle counter clears and the key is processed.

## Test plan
- Reset, then pulse MODE with inputs 13:45:30: Set_field=1 and outputs 13:45:30. Pulse UP 11 times: Hour_out wraps 23->0. End at 0.
- In SET_MIN with Minute_out=0, pulse DOWN once: Minute_out=59. Pulse MODE: SET_SEC. Pulse MODE again: Set_field=0 and Load_en high for exactly 1 cycle with 0:59:30.
- In SET_HOUR, drive MODE and UP low in the same cycle: state advances to SET_MIN and Hour_out is unchanged. Drive CANCEL+MODE together: RUN with no Load_en.
- Enter SET_HOUR and apply no keys: Set_field returns to 0 exactly TIMEOUT_MS cycles after entry, with Load_en never asserted. Blink toggles every BLINK_HALF cycles meanwhile.
- Assert Reset asynchronously mid-SET_MIN: all outputs take their reset values immediately, without a clock edge. After release, Load_en stays 0 and the FSM is in RUN.
- In SET_SEC with Blink=0, pulse UP: Blink=1 the next cycle and stays 1 for BLINK_HALF cycles.
